// File: rtl/hazard_control_unit.sv
// Hazard control for the 16-bit MINI-RISC pipeline.
// Freezes the front of the pipeline while a multi-cycle data-memory read sits
// in Execute, squashes Fetch/Decode on taken branches, steers Writeback
// forwarding to the Decode and Execute operands, and counts stall cycles and
// flush events in saturating performance counters.
module hazard_control_unit #(
  parameter int MEM_LAT = 3,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  rs1_D,
  input  logic [2:0]  rs2_D,
  input  logic [2:0]  rs1_E,
  input  logic [2:0]  rs2_E,
  input  logic        mem_read_E,
  input  logic        branch_taken_E,
  input  logic [2:0]  rd_W,
  input  logic [1:0]  write_mode_W,
  input  logic        perf_clr,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        flush_F,
  output logic        flush_D,
  output logic        fwd_a_D,
  output logic        fwd_b_D,
  output logic        fwd_a_E,
  output logic        fwd_b_E,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        busy
);

  // Number of cycles a read holds the pipeline.
  localparam int N = MEM_LAT - 1;
  localparam bit CAN_STALL = (N >= 1);
  // WAIT is entered after the first stall cycle with this many stalls left.
  localparam logic [7:0] WAIT_INIT = (N > 1) ? 8'(N - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       stall;
  logic       flush;

  // Forwarding match: Writeback writes the register the operand reads.
  function automatic logic fwd_match(input logic [2:0] rs, input logic [2:0] rd,
                                     input logic [1:0] wm);
    return (wm != 2'd0) && (rd == rs) && !(R0_ZERO && (rd == 3'd0));
  endfunction

  // Stall decode: first stall cycle comes straight from IDLE, WAIT always stalls,
  // and reset masks everything so the stalls drop the moment reset rises.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      stall = 1'b0;
    end else begin
      case (state)
        IDLE:    stall = CAN_STALL & mem_read_E;
        WAIT:    stall = 1'b1;
        RELEASE: stall = 1'b0;
        default: stall = 1'b0;
      endcase
    end
  end

  // A branch held in E during a stall flushes in the first unstalled cycle.
  assign flush   = branch_taken_E & ~stall & ~reset;

  assign stall_F = stall;
  assign stall_D = stall;
  assign stall_E = stall;
  assign flush_F = flush;
  assign flush_D = flush;
  assign busy    = (state != IDLE);

  assign fwd_a_D = fwd_match(rs1_D, rd_W, write_mode_W);
  assign fwd_b_D = fwd_match(rs2_D, rd_W, write_mode_W);
  assign fwd_a_E = fwd_match(rs1_E, rd_W, write_mode_W);
  assign fwd_b_E = fwd_match(rs2_E, rd_W, write_mode_W);

  // Memory-read stall sequencer; RELEASE lets the held read advance out of E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (CAN_STALL && mem_read_E) begin
            if (N == 1) begin
              state <= RELEASE;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (perf_clr) begin
        stall_cnt <= 16'd0;
      end else if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (perf_clr) begin
        flush_cnt <= 16'd0;
      end else if (flush && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule
